// File: rtl/device_uart_if.sv
`default_nettype none
// ============================================================================
// Module   : device_uart_if
// Purpose  : Cluster device-bus bundle between the cluster (master) and a
//            memory-mapped device (slave).
// Signals  : device_core_id  - ID of core owning the bus this cycle
//            device_write_en - single-cycle write strobe
//            device_read_en  - single-cycle read strobe
//            device_addr     - 10-bit word address
//            device_data_out - write data from the cluster
//            device_data_in  - read data returned to the cluster
// Revision : 1.0 - initial release
// ============================================================================
interface device_uart_if;
  logic [3:0]  device_core_id;
  logic        device_write_en;
  logic        device_read_en;
  logic [9:0]  device_addr;
  logic [15:0] device_data_out;
  logic [15:0] device_data_in;

  modport master (
    output device_core_id, device_write_en, device_read_en,
    output device_addr, device_data_out,
    input  device_data_in
  );

  modport slave (
    input  device_core_id, device_write_en, device_read_en,
    input  device_addr, device_data_out,
    output device_data_in
  );
endinterface
`default_nettype wire

// File: rtl/device_uart.sv
`default_nettype none
// ============================================================================
// Module   : device_uart
// Purpose  : Memory-mapped 8N1 UART on the cluster device bus. 8-word
//            register window, 1-cycle read latency, TX FIFO, single RX
//            holding register with overrun / framing error flags.
// Ports    : clk, reset_n (async, active low)
//            bus      - device bus, slave modport
//            uart_tx  - serial output, idle high
//            uart_rx  - serial input, asynchronous
// Revision : 1.0 - initial release
// ============================================================================
module device_uart #(
  parameter logic [9:0]  BASE_ADDR       = 10'h000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  wire           clk,
  input  wire           reset_n,
  device_uart_if.slave  bus,
  output logic          uart_tx,
  input  wire           uart_rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // ---------------- bus decode ----------------
  logic       match, rd, wr;
  logic [2:0] off;
  logic       rd_status, rd_rxdata, wr_tx, wr_div;

  assign match     = (bus.device_addr[9:3] == BASE_ADDR[9:3]);
  assign off       = bus.device_addr[2:0];
  assign rd        = bus.device_read_en & match;
  assign wr        = bus.device_write_en & match;
  assign rd_status = rd & (off == 3'd0);
  assign rd_rxdata = rd & (off == 3'd2);
  assign wr_tx     = wr & (off == 3'd1);
  assign wr_div    = wr & (off == 3'd3);

  logic [15:0] divisor;
  logic [3:0]  tx_core;
  logic [15:0] data_in;
  logic        rx_valid, rx_overrun, rx_frame_err, tx_overflow;
  logic [7:0]  rx_byte;

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_tx & ~full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.device_data_out[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end, tx_line, tx_idle;

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  assign tx_idle    = empty & (tx_state == TX_IDLE);

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE: if (!empty) begin
        pop     = 1'b1;
        tx_next = TX_START;
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
      end
      TX_STOP: if (tx_bit_end) begin
        // Chain straight into the next start bit so queued bytes have no gap.
        if (!empty) begin
          pop     = 1'b1;
          tx_next = TX_START;
        end else begin
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // uart_tx is registered from the current state, which places the start
  // bit two edges after the FIFO write and keeps every bit exactly tx_div long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_div   <= DEFAULT_DIVISOR;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      uart_tx  <= tx_line;
      if (pop) begin
        tx_shift <= fifo_mem[rd_ptr];
        tx_div   <= divisor;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_state == TX_DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t   rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_div, rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_fall, rx_half_end, rx_bit_end, rx_done, rx_ferr;

  assign rx_fall     = rx_prev & ~rx_s2;
  assign rx_half_end = (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1);
  assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half_end) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bit_end) begin
        if (rx_s2) begin
          rx_done = 1'b1;
          rx_next = RX_IDLE;
        end else begin
          rx_ferr = 1'b1;
          rx_next = RX_BREAK;
        end
      end
      RX_BREAK: if (rx_s2) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_div   <= DEFAULT_DIVISOR;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_div <= divisor;
        end
        RX_START: begin
          rx_bit <= '0;
          rx_cnt <= rx_half_end ? 16'd0 : rx_cnt + 16'd1;
        end
        RX_DATA, RX_STOP: begin
          if (rx_bit_end) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

  // ---------------- registers and flags ----------------
  // A byte completing while RX_DATA is read replaces the old one cleanly.
  logic overrun_set;
  assign overrun_set = rx_done & rx_valid & ~rd_rxdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor      <= DEFAULT_DIVISOR;
      tx_core      <= '0;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_overflow  <= 1'b0;
      data_in      <= '0;
    end else begin
      if (wr_div)
        divisor <= (bus.device_data_out < 16'd2) ? 16'd2 : bus.device_data_out;
      if (push) tx_core <= bus.device_core_id;

      if (rx_done && !overrun_set) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_rxdata) begin
        rx_valid <= 1'b0;
      end

      // Set has priority over the clear-on-read of STATUS.
      rx_overrun   <= overrun_set        | (rx_overrun   & ~rd_status);
      rx_frame_err <= rx_ferr            | (rx_frame_err & ~rd_status);
      tx_overflow  <= (wr_tx & full)     | (tx_overflow  & ~rd_status);

      if (rd) begin
        case (off)
          3'd0:    data_in <= {8'(count), 2'b00, tx_overflow, rx_frame_err,
                               rx_overrun, rx_valid, tx_idle, full};
          3'd2:    data_in <= {8'h00, rx_byte};
          3'd3:    data_in <= divisor;
          3'd4:    data_in <= {12'h000, tx_core};
          default: data_in <= '0;
        endcase
      end
    end
  end

  assign bus.device_data_in = data_in;
endmodule
`default_nettype wire

// File: doc/device_uart.md
# device_uart

Memory-mapped UART peripheral that responds on the cluster's device bus: the slave end of the device read/write interface the cluster drives for addresses 0xFC00–0xFFFF. It decodes an 8-word register window within the 10-bit device address space, returns read data one cycle after the read strobe to match global-memory read timing, and runs an 8N1 serial transmitter (with TX FIFO) and receiver (with single holding register).

## Interface
- BASE_ADDR, 10'h000: window base, aligned to 8 words; match when device_addr[9:3] == BASE_ADDR[9:3].
- FIFO_DEPTH, 8: TX FIFO entries (power of two, 2..64).
- DEFAULT_DIVISOR, 16'd434: clocks per bit after reset.

- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- device_core_id  input  4  binary ID of core owning the bus this cycle.
- device_write_en  input  1  write strobe, single cycle.
- device_read_en  input  1  read strobe, single cycle.
- device_addr  input  10  word address.
- device_data_out  input  16  write data from cluster.
- device_data_in  output  16  read data to cluster.
- uart_tx  output  1  serial out, idle high.
- uart_rx  input  1  serial in, asynchronous.

## Operation
- Register map (offset = device_addr[2:0]):
  - 0 STATUS (R): [0] tx_full, [1] tx_idle (FIFO empty and TX FSM idle), [2] rx_valid, [3] rx_overrun, [4] rx_frame_err, [5] tx_overflow, [7:6] 0, [15:8] TX FIFO count. Reading clears [3],[4],[5].
  - 1 TX_DATA (W): push device_data_out[7:0]; reads return 0.
  - 2 RX_DATA (R): {8'h0, rx_byte}; clears rx_valid.
  - 3 DIVISOR (R/W): writes below 2 store 2.
  - 4 TX_CORE (R): {12'h0, device_core_id of last accepted TX_DATA write}.
  - 5–7: reads 0, writes ignored. Unmatched addresses: no effect, device_data_in unchanged.
- TX write while full: byte dropped, tx_overflow set, count unchanged.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE, or STOP -> START directly when FIFO nonempty. Divisor latched at byte load; each bit lasts exactly latched-divisor clocks.
- RX: uart_rx through 2-flop synchronizer. FSM IDLE -> START on synchronized falling edge; at divisor/2 clocks recheck low, else back to IDLE (glitch). DATA samples 8 bits at divisor intervals; STOP samples once more.
  - Stop high, rx_valid clear: load rx_byte, set rx_valid.
  - Stop high, rx_valid set: discard byte, set rx_overrun.
  - Stop low: discard, set rx_frame_err; return to IDLE only once line is high.
- Simultaneous events: RX_DATA read in the same cycle a new byte completes -> new byte loaded, rx_valid stays 1, no overrun. STATUS read in the same cycle a flag sets -> flag stays set (set wins). FIFO push and pop together -> count unchanged.

## Timing
- Reset (asserted any time, mid-frame included): device_data_in=0, uart_tx=1, FIFO empty, all flags 0, divisor=DEFAULT_DIVISOR, TX_CORE=0, both FSMs IDLE. Frame in progress is abandoned.
- Read latency 1: device_read_en at edge N -> device_data_in valid from N+1, held until the next matching read. Read side effects occur at edge N.
- Write takes effect at the edge where device_write_en is sampled.
- TX: TX_DATA write at edge N with FSM idle -> uart_tx low from edge N+2. Frame is 10×divisor clocks; back-to-back bytes have no idle gap.
- RX: rx_valid rises ≤ 3 clocks after the stop-bit sample point.

## Test plan
- Reset: release reset_n, read STATUS -> 16'h0002; DIVISOR -> 434; uart_tx=1.
- TX: write DIVISOR=4, TX_DATA=8'hA5 from core 7 -> uart_tx low 2 cycles after write, then bits 1,0,1,0,0,1,0,1, stop high, each 4 clocks; TX_CORE reads 7.
- FIFO full: 10 TX writes while DIVISOR=100 -> STATUS [0]=1, [5]=1, [15:8]=8 or 7 per timing; second STATUS read [5]=0; exactly 9 frames sent (1 in shifter + 8).
- RX: drive 8'h3C at DIVISOR=8 -> rx_valid=1, RX_DATA reads 16'h003C, then STATUS[2]=0.
- RX errors: two bytes without reading -> rx_overrun set, RX_DATA still first byte; frame with stop bit low -> rx_frame_err, rx_valid unchanged; 2-clock low glitch -> no flags.
- Reset mid-frame: assert reset_n low during TX data bit 3 -> uart_tx=1 immediately, FIFO empty after release.
